// File: rtl/fft_butterfly_2.sv
// Pipelined radix-2 DIT butterfly: X = A + B*W, Y = A - B*W with Q7 twiddles,
// optional /2 scaling, saturation and a sticky overflow flag. Three ce-gated stages.
module fft_butterfly_2 #(
   parameter int DW    = 12,
   parameter int TW    = 12,
   parameter bit SCALE = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] a_re,
   input  logic signed [DW-1:0] a_im,
   input  logic signed [DW-1:0] b_re,
   input  logic signed [DW-1:0] b_im,
   input  logic signed [TW-1:0] tw_re,
   input  logic signed [TW-1:0] tw_im,
   output logic                 out_valid,
   output logic signed [DW-1:0] x_re,
   output logic signed [DW-1:0] x_im,
   output logic signed [DW-1:0] y_re,
   output logic signed [DW-1:0] y_im,
   output logic                 ovf
);

   localparam int PW   = DW + TW;
   localparam int SW   = DW + TW + 1;
   localparam int FRAC = 7;
   localparam logic signed [SW-1:0] SAT_MAX = SW'((1 <<< (DW - 1)) - 1);
   localparam logic signed [SW-1:0] SAT_MIN = SW'(-(1 <<< (DW - 1)));

   logic                 v1_q;
   logic signed [DW-1:0] a1Re_q, a1Im_q, b1Re_q, b1Im_q;
   logic signed [TW-1:0] w1Re_q, w1Im_q;

   logic                 v2_q;
   logic signed [DW-1:0] a2Re_q, a2Im_q;
   logic signed [PW-1:0] pr1_q, pr2_q, pi1_q, pi2_q;
   logic signed [PW-1:0] pr1_d, pr2_d, pi1_d, pi2_d;

   logic                 v3_q;
   logic signed [DW-1:0] xRe_q, xIm_q, yRe_q, yIm_q;
   logic signed [DW-1:0] xRe_d, xIm_d, yRe_d, yIm_d;
   logic                 ovf_q, ovf_d;

   logic signed [SW-1:0] tRe, tIm, aRe, aIm;
   logic signed [SW-1:0] sumXRe, sumXIm, sumYRe, sumYIm;
   logic                 anyClip;

   function automatic logic signed [DW-1:0] saturate(input logic signed [SW-1:0] v);
      if (v > SAT_MAX) begin
         return SAT_MAX[DW-1:0];
      end else if (v < SAT_MIN) begin
         return SAT_MIN[DW-1:0];
      end
      return v[DW-1:0];
   endfunction

   function automatic logic clips(input logic signed [SW-1:0] v);
      return (v > SAT_MAX) || (v < SAT_MIN);
   endfunction

   // Stage 1: capture the operand pair and its twiddle alongside the valid tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q   <= 1'b0;
         a1Re_q <= '0;
         a1Im_q <= '0;
         b1Re_q <= '0;
         b1Im_q <= '0;
         w1Re_q <= '0;
         w1Im_q <= '0;
      end else if (ce) begin
         v1_q   <= in_valid;
         a1Re_q <= a_re;
         a1Im_q <= a_im;
         b1Re_q <= b_re;
         b1Im_q <= b_im;
         w1Re_q <= tw_re;
         w1Im_q <= tw_im;
      end
   end

   always_comb begin
      pr1_d = PW'(b1Re_q) * PW'(w1Re_q);
      pr2_d = PW'(b1Im_q) * PW'(w1Im_q);
      pi1_d = PW'(b1Re_q) * PW'(w1Im_q);
      pi2_d = PW'(b1Im_q) * PW'(w1Re_q);
   end

   // Stage 2: full-precision partial products; A is only delayed.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2_q   <= 1'b0;
         a2Re_q <= '0;
         a2Im_q <= '0;
         pr1_q  <= '0;
         pr2_q  <= '0;
         pi1_q  <= '0;
         pi2_q  <= '0;
      end else if (ce) begin
         v2_q   <= v1_q;
         a2Re_q <= a1Re_q;
         a2Im_q <= a1Im_q;
         pr1_q  <= pr1_d;
         pr2_q  <= pr2_d;
         pi1_q  <= pi1_d;
         pi2_q  <= pi2_d;
      end
   end

   // Floor-rounded Q7 product, then the add/subtract, optional halving and clipping.
   always_comb begin
      tRe    = (SW'(pr1_q) - SW'(pr2_q)) >>> FRAC;
      tIm    = (SW'(pi1_q) + SW'(pi2_q)) >>> FRAC;
      aRe    = SW'(a2Re_q);
      aIm    = SW'(a2Im_q);
      sumXRe = aRe + tRe;
      sumXIm = aIm + tIm;
      sumYRe = aRe - tRe;
      sumYIm = aIm - tIm;
      if (SCALE) begin
         sumXRe = sumXRe >>> 1;
         sumXIm = sumXIm >>> 1;
         sumYRe = sumYRe >>> 1;
         sumYIm = sumYIm >>> 1;
      end
      xRe_d   = saturate(sumXRe);
      xIm_d   = saturate(sumXIm);
      yRe_d   = saturate(sumYRe);
      yIm_d   = saturate(sumYIm);
      anyClip = clips(sumXRe) | clips(sumXIm) | clips(sumYRe) | clips(sumYIm);
      ovf_d   = ovf_q | (v2_q & anyClip);
   end

   // Stage 3: result registers and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         v3_q  <= 1'b0;
         xRe_q <= '0;
         xIm_q <= '0;
         yRe_q <= '0;
         yIm_q <= '0;
         ovf_q <= 1'b0;
      end else if (ce) begin
         v3_q  <= v2_q;
         xRe_q <= xRe_d;
         xIm_q <= xIm_d;
         yRe_q <= yRe_d;
         yIm_q <= yIm_d;
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = v3_q;
   assign x_re      = xRe_q;
   assign x_im      = xIm_q;
   assign y_re      = yRe_q;
   assign y_im      = yIm_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_butterfly_2.sv
// Directed bench for fft_butterfly_2: hand-computed butterflies, saturation,
// ce stalls mid-stream and reset flushing of in-flight pairs.
module tb_fft_butterfly_2;

   localparam int DW = 12;
   localparam int TW = 12;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 ce;
   logic                 in_valid;
   logic signed [DW-1:0] a_re, a_im, b_re, b_im;
   logic signed [TW-1:0] tw_re, tw_im;
   logic                 out_valid;
   logic signed [DW-1:0] x_re, x_im, y_re, y_im;
   logic                 ovf;

   int totalChecks = 0;
   int badChecks   = 0;

   logic [47:0] obsQ[$];
   logic        edgeCe;

   always #5 clk = ~clk;

   fft_butterfly_2 #(.DW(DW), .TW(TW), .SCALE(1'b0)) dut (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .in_valid (in_valid),
      .a_re     (a_re),
      .a_im     (a_im),
      .b_re     (b_re),
      .b_im     (b_im),
      .tw_re    (tw_re),
      .tw_im    (tw_im),
      .out_valid(out_valid),
      .x_re     (x_re),
      .x_im     (x_im),
      .y_re     (y_re),
      .y_im     (y_im),
      .ovf      (ovf)
   );

   // Collect every result produced by a ce-enabled edge, in arrival order.
   always @(posedge clk) edgeCe <= ce;

   always @(posedge clk) begin
      #1;
      if (edgeCe === 1'b1 && out_valid === 1'b1) begin
         obsQ.push_back({x_re, x_im, y_re, y_im});
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [47:0] pack(input int xr, input int xi, input int yr, input int yi);
      return {xr[11:0], xi[11:0], yr[11:0], yi[11:0]};
   endfunction

   task automatic applyStimulus(input int ar, input int ai, input int br, input int bi,
                                input int wr, input int wi);
      in_valid = 1'b1;
      a_re     = DW'(ar);
      a_im     = DW'(ai);
      b_re     = DW'(br);
      b_im     = DW'(bi);
      tw_re    = TW'(wr);
      tw_im    = TW'(wi);
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      in_valid = 1'b0;
      a_re     = DW'(-1);
      b_re     = DW'(-1);
      repeat (n) @(negedge clk);
   endtask

   task automatic expectOne(input string tag, input logic [47:0] expected);
      checkOutput({tag, "_count"}, 64'(obsQ.size()), 64'd1);
      if (obsQ.size() > 0) checkOutput(tag, 64'(obsQ[0]), 64'(expected));
      obsQ.delete();
   endtask

   initial begin
      rst = 1'b1; ce = 1'b0; in_valid = 1'b0;
      a_re = '0; a_im = '0; b_re = '0; b_im = '0; tw_re = '0; tw_im = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_ovf", 64'(ovf), 64'd0);
      checkOutput("rst_data", 64'({x_re, x_im, y_re, y_im}), 64'd0);
      rst = 1'b0; ce = 1'b1;
      obsQ.delete();

      // Basic butterfly, also checking the three-edge latency.
      applyStimulus(100, 0, 50, 0, 127, 0);
      idleCycles(1);
      checkOutput("lat_edge2_valid", 64'(out_valid), 64'd0);
      idleCycles(1);
      checkOutput("lat_edge3_valid", 64'(out_valid), 64'd1);
      idleCycles(2);
      expectOne("basic_w127", pack(149, 0, 51, 0));

      applyStimulus(100, 0, 50, 0, 0, -127);
      idleCycles(4);
      expectOne("floor_neg_w", pack(100, -50, 100, 50));

      applyStimulus(0, 0, 100, 0, 90, 90);
      idleCycles(4);
      expectOne("diag_w", pack(70, 70, -70, -70));
      checkOutput("ovf_clean", 64'(ovf), 64'd0);

      // Positive clip, then a clean pair must leave the overflow flag set.
      applyStimulus(2047, 0, 2047, 0, 127, 0);
      idleCycles(4);
      expectOne("sat_pos", pack(2047, 0, 16, 0));
      checkOutput("ovf_set", 64'(ovf), 64'd1);
      applyStimulus(100, 0, 50, 0, 127, 0);
      idleCycles(4);
      expectOne("after_sat", pack(149, 0, 51, 0));
      checkOutput("ovf_sticky", 64'(ovf), 64'd1);

      // Eight back-to-back pairs with a two-cycle ce stall in the middle.
      for (int i = 0; i < 4; i++) applyStimulus(100 * i - 300, 7 * i, 40 * i, -20 * i, 64, 0);
      ce = 1'b0;
      idleCycles(2);
      ce = 1'b1;
      for (int i = 4; i < 8; i++) applyStimulus(100 * i - 300, 7 * i, 40 * i, -20 * i, 64, 0);
      idleCycles(5);
      checkOutput("stream_count", 64'(obsQ.size()), 64'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < obsQ.size()) begin
            checkOutput($sformatf("stream_%0d", i), 64'(obsQ[i]),
                        64'(pack(120 * i - 300, -3 * i, 80 * i - 300, 17 * i)));
         end
      end
      obsQ.delete();

      // Reset with two pairs in flight: nothing may emerge afterwards.
      applyStimulus(1000, 0, 500, 0, 127, 0);
      applyStimulus(-500, 20, 300, 10, 64, 64);
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("flush_valid", 64'(out_valid), 64'd0);
      checkOutput("flush_ovf", 64'(ovf), 64'd0);
      checkOutput("flush_data", 64'({x_re, x_im, y_re, y_im}), 64'd0);
      rst = 1'b0;
      idleCycles(5);
      checkOutput("flush_none", 64'(obsQ.size()), 64'd0);
      obsQ.delete();

      // Negative clip after reset raises the flag again.
      applyStimulus(-2048, 0, 2047, 0, 127, 0);
      idleCycles(4);
      expectOne("sat_neg", pack(-17, 0, -2048, 0));
      checkOutput("ovf_reset_then_set", 64'(ovf), 64'd1);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
